nv_blkbox_src_gen: RTL and testbench



---
 rtl/nv_blkbox_src_gen_pkg.sv | 29 ++
 rtl/nv_blkbox_src_gen_if.sv | 29 ++
 rtl/nv_blkbox_lfsr32.sv | 33 +++
 rtl/nv_blkbox_src_gen.sv | 121 ++++++++++++
 tb/tb_nv_blkbox_src_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/nv_blkbox_src_gen_pkg.sv
// nv_blkbox_src_gen_pkg
// Shared definitions for the block-box source: FSM state encoding, the LFSR
// feedback polynomial, the beat counter width and small LFSR helpers.
package nv_blkbox_src_gen_pkg;

  // Burst sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } srcState_e;

  // Galois feedback taps for the 32-bit right-shifting LFSR
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Width of the beat counter and of the programmed burst length
  localparam int BEAT_CNT_W = 16;

  // One step of the right-shifting Galois LFSR
  function automatic logic [31:0] lfsrNext(input logic [31:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1
  function automatic logic [31:0] seedFix(input logic [31:0] seed);
    return (seed == 32'h0) ? 32'h1 : seed;
  endfunction

endpackage

// File: rtl/nv_blkbox_src_gen_if.sv
// nv_blkbox_src_gen_if
// Valid/ready payload channel driven by the block-box source. The master
// modport is the producing side, the slave modport is the consumer.
interface nv_blkbox_src_gen_if #(
  parameter int WIDTH = 32
);

  logic             src_pvld;
  logic             src_prdy;
  logic [WIDTH-1:0] src_pd;
  logic             src_last;

  // Producer view: drives valid, payload and last, samples ready
  modport master (
    output src_pvld,
    output src_pd,
    output src_last,
    input  src_prdy
  );

  // Consumer view: samples valid, payload and last, drives ready
  modport slave (
    input  src_pvld,
    input  src_pd,
    input  src_last,
    output src_prdy
  );

endinterface

// File: rtl/nv_blkbox_lfsr32.sv
// nv_blkbox_lfsr32
// 32-bit right-shifting Galois LFSR. Load restarts the sequence at SEED
// (zero promoted to 1) and takes priority over advance.
module nv_blkbox_lfsr32
  import nv_blkbox_src_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [31:0] o_q
);

  localparam logic [31:0] SEED_EFF = seedFix(SEED);

  logic [31:0] r_q;

  // Hold, restart at the seed, or step the sequence by one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= SEED_EFF;
    end else if (i_load) begin
      r_q <= SEED_EFF;
    end else if (i_advance) begin
      r_q <= lfsrNext(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/nv_blkbox_src_gen.sv
// nv_blkbox_src_gen
// Stand-in producer for a valid/ready channel whose real source is absent.
// Emits bursts of cfg_len beats (0 = unbounded) with a zero payload, or an
// LFSR pattern when NV_BLKBOX_SRC_LFSR_EN is defined. All outputs come
// straight from flops, so there is no input-to-output combinational path.
module nv_blkbox_src_gen
  import nv_blkbox_src_gen_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  cfg_en,
  input  logic [BEAT_CNT_W-1:0] cfg_len,
  nv_blkbox_src_gen_if.master   src,
  output logic                  done,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  srcState_e             r_state;
  logic [BEAT_CNT_W-1:0] r_len;
  logic [BEAT_CNT_W-1:0] r_beatCnt;
  logic                  r_pvld;
  logic                  r_last;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_isFinal;
  logic [BEAT_CNT_W-1:0] w_lenM1;
  logic [BEAT_CNT_W-1:0] w_cntInc;

  assign w_accept  = r_pvld & src.src_prdy;
  assign w_start   = (r_state == ST_IDLE) & cfg_en;
  assign w_lenM1   = r_len - 1'b1;
  assign w_cntInc  = r_beatCnt + 1'b1;
  assign w_isFinal = (r_len != '0) & (r_beatCnt == w_lenM1);

  // Burst sequencer: exits are only taken on an accepted beat, so a raised
  // beat is never withdrawn; last is precomputed for the beat being offered
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_beatCnt <= '0;
      r_pvld    <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_en) begin
            r_state   <= ST_RUN;
            r_len     <= cfg_len;
            r_beatCnt <= '0;
            r_pvld    <= 1'b1;
            r_last    <= (cfg_len == 16'd1);
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_beatCnt <= w_cntInc;
            if (w_isFinal) begin
              r_state <= ST_DONE;
              r_pvld  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else if (!cfg_en) begin
              r_state <= ST_IDLE;
              r_pvld  <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_last  <= (r_len != '0) & (w_cntInc == w_lenM1);
            end
          end
        end
        ST_DONE: begin
          if (!cfg_en) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pvld  <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign src.src_pvld = r_pvld;
  assign src.src_last = r_last;
  assign done         = r_done;
  assign beat_cnt     = r_beatCnt;

`ifdef NV_BLKBOX_SRC_LFSR_EN
  logic [31:0] w_lfsrQ;

  nv_blkbox_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .i_load    (w_start),
    .i_advance (w_accept),
    .o_q       (w_lfsrQ)
  );

  // Payload is forced to zero whenever no beat is offered, so idle and reset
  // present a clean zero instead of the parked LFSR value
  assign src.src_pd = r_pvld ? w_lfsrQ[WIDTH-1:0] : '0;
`else
  // Pure zero tie-off; SEED has no meaning here and is masked away
  assign src.src_pd = WIDTH'(SEED & 32'h0) | {{(WIDTH-1){1'b0}}, w_start & 1'b0};
`endif

endmodule

// File: tb/tb_nv_blkbox_src_gen.sv
// tb_nv_blkbox_src_gen
// Drives nv_blkbox_src_gen through directed bursts and random traffic and
// compares every cycle against a burst-level reference model. The expected
// payload follows the LFSR when NV_BLKBOX_SRC_LFSR_EN is defined, else zero.
module tb_nv_blkbox_src_gen;

  localparam int          WIDTH = 32;
  localparam logic [31:0] SEED  = 32'h0000_0001;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rst = 1'b1;
  logic        cfg_en         = 1'b0;
  logic [15:0] cfg_len        = 16'd0;
  logic        done;
  logic [15:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: phase 0 idle, 1 streaming, 2 finished
  int          mPhase;
  int          mLen;
  int          mCnt;
  logic [31:0] mLfsr;

  nv_blkbox_src_gen_if #(.WIDTH(WIDTH)) srcIf ();

  nv_blkbox_src_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .cfg_en         (cfg_en),
    .cfg_len        (cfg_len),
    .src            (srcIf),
    .done           (done),
    .beat_cnt       (beat_cnt)
  );

  // Free-running 10-unit clock
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Next pattern word, straight from the polynomial definition
  function automatic logic [31:0] refStep(input logic [31:0] q);
    logic [31:0] fb;
    fb = q[0] ? 32'h8020_0003 : 32'h0;
    return (q >> 1) ^ fb;
  endfunction

  // Single comparison point: counts and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive the next set of inputs
  task automatic applyStimulus(input logic en, input logic prdy, input logic [15:0] len);
    cfg_en         = en;
    srcIf.src_prdy = prdy;
    cfg_len        = len;
  endtask

  // Model reset: nothing survives
  task automatic modelReset();
    mPhase = 0;
    mLen   = 0;
    mCnt   = 0;
    mLfsr  = (SEED == 32'h0) ? 32'h1 : SEED;
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic modelEdge();
    bit taken;
    taken = (mPhase == 1) && (srcIf.src_prdy == 1'b1);
    case (mPhase)
      0: if (cfg_en) begin
           mPhase = 1;
           mLen   = int'(cfg_len);
           mCnt   = 0;
           mLfsr  = (SEED == 32'h0) ? 32'h1 : SEED;
         end
      1: if (taken) begin
           mCnt  = (mCnt + 1) % 65536;
           mLfsr = refStep(mLfsr);
           if (mLen != 0 && mCnt == mLen) mPhase = 2;
           else if (!cfg_en)              mPhase = 0;
         end
      default: if (!cfg_en) mPhase = 0;
    endcase
  endtask

  // Compare every output with what the model says should be visible now
  task automatic checkAll(input string tag);
    logic        expPvld;
    logic        expLast;
    logic [31:0] expPd;
    expPvld = (mPhase == 1);
    expLast = (mPhase == 1) && (mLen != 0) && (mCnt == mLen - 1);
`ifdef NV_BLKBOX_SRC_LFSR_EN
    expPd = expPvld ? mLfsr : 32'h0;
`else
    expPd = 32'h0;
`endif
    checkOutput({tag, ".pvld"}, 32'(srcIf.src_pvld), 32'(expPvld));
    checkOutput({tag, ".last"}, 32'(srcIf.src_last), 32'(expLast));
    checkOutput({tag, ".pd"},   32'(srcIf.src_pd),   expPd);
    checkOutput({tag, ".done"}, 32'(done),           32'(mPhase == 2));
    checkOutput({tag, ".cnt"},  32'(beat_cnt),       32'(mCnt));
  endtask

  // One clock: let the DUT and model advance, then compare 1 unit later
  task automatic tick(input string tag);
    @(posedge nvdla_core_clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulseReset();
    #1;
    nvdla_core_rst = 1'b1;
    #1;
    modelReset();
    checkAll("rstPulse");
    checkOutput("rstPulse.pvldZero", 32'(srcIf.src_pvld), 32'h0);
    checkOutput("rstPulse.pdZero",   32'(srcIf.src_pd),   32'h0);
    checkOutput("rstPulse.cntZero",  32'(beat_cnt),       32'h0);
    #1;
    nvdla_core_rst = 1'b0;
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    srcIf.src_prdy = 1'b0;
    modelReset();
    #2;
    checkAll("reset");
    checkOutput("reset.done", 32'(done), 32'h0);
    #1;
    nvdla_core_rst = 1'b0;

    // Three-beat burst at full throughput
    applyStimulus(1'b1, 1'b1, 16'd3);
    tick("b3.start");
`ifdef NV_BLKBOX_SRC_LFSR_EN
    checkOutput("b3.pd0", 32'(srcIf.src_pd), 32'h0000_0001);
`endif
    tick("b3.beat1");
`ifdef NV_BLKBOX_SRC_LFSR_EN
    checkOutput("b3.pd1", 32'(srcIf.src_pd), 32'h8020_0003);
`endif
    tick("b3.beat2");
`ifdef NV_BLKBOX_SRC_LFSR_EN
    checkOutput("b3.pd2", 32'(srcIf.src_pd), 32'hC030_0002);
`endif
    checkOutput("b3.last", 32'(srcIf.src_last), 32'h1);
    tick("b3.end");
    checkOutput("b3.done", 32'(done), 32'h1);
    checkOutput("b3.cnt",  32'(beat_cnt), 32'd3);
    tick("b3.hold");
    applyStimulus(1'b0, 1'b1, 16'd3);
    tick("b3.clear");
    checkOutput("b3.doneClr", 32'(done), 32'h0);

    // Four-beat burst (zero payload when the LFSR is compiled out)
    applyStimulus(1'b1, 1'b1, 16'd4);
    for (int i = 0; i < 5; i++) tick("b4");
    checkOutput("b4.done", 32'(done), 32'h1);
    checkOutput("b4.cnt",  32'(beat_cnt), 32'd4);
    applyStimulus(1'b0, 1'b0, 16'd0);
    tick("b4.clear");

    // Backpressure for five cycles in the middle of a burst
    applyStimulus(1'b1, 1'b1, 16'd8);
    for (int i = 0; i < 3; i++) tick("bp.pre");
    applyStimulus(1'b1, 1'b0, 16'd8);
    for (int i = 0; i < 5; i++) tick("bp.stall");
    checkOutput("bp.cntHeld", 32'(beat_cnt), 32'd2);
    applyStimulus(1'b1, 1'b1, 16'd8);
    for (int i = 0; i < 7; i++) tick("bp.post");
    checkOutput("bp.done", 32'(done), 32'h1);
    applyStimulus(1'b0, 1'b1, 16'd0);
    tick("bp.clear");

    // Enable dropped while a beat is stalled: beat held, then back to idle
    applyStimulus(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) tick("drop.stall");
    applyStimulus(1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 2; i++) tick("drop.held");
    checkOutput("drop.stillValid", 32'(srcIf.src_pvld), 32'h1);
    applyStimulus(1'b0, 1'b1, 16'd0);
    tick("drop.accept");
    checkOutput("drop.idle", 32'(srcIf.src_pvld), 32'h0);

    // Reset in the middle of a burst, then a fresh burst
    applyStimulus(1'b1, 1'b1, 16'd5);
    for (int i = 0; i < 3; i++) tick("rst.pre");
    pulseReset();
    tick("rst.restart");
    checkOutput("rst.cnt0", 32'(beat_cnt), 32'h0);
`ifdef NV_BLKBOX_SRC_LFSR_EN
    checkOutput("rst.seed", 32'(srcIf.src_pd), SEED);
`endif
    for (int i = 0; i < 5; i++) tick("rst.run");
    applyStimulus(1'b0, 1'b0, 16'd0);
    tick("rst.clear");

    // Unbounded burst of 70000 beats: counter wraps, no last, no done
    applyStimulus(1'b1, 1'b1, 16'd0);
    tick("wrap.start");
    for (int i = 0; i < 70000; i++) tick("wrap");
    checkOutput("wrap.cnt",  32'(beat_cnt), 32'd4464);
    checkOutput("wrap.done", 32'(done), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'd0);
    tick("wrap.stop");

    // Random enable, ready, length and occasional reset
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                    16'($urandom_range(0, 6)));
      tick("rand");
      if ($urandom_range(0, 499) == 0) pulseReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
